// File: rtl/ico_pkg.sv
// Shared definitions for the ICO sweep controller.
// Holds the increment and dwell widths, the system clock rate, the sweep state
// encoding and the dwell reload helper.
// Build option: SWEEP_TRIANGLE_EN adds the TURN state used by the up/down sweep.
package ico_pkg;

  localparam int unsigned INC_W   = 15;
  localparam int unsigned DWELL_W = 24;
  localparam int unsigned FS_HZ   = 40_000_000;

`ifdef SWEEP_TRIANGLE_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DWELL  = 3'd1,
    STEP   = 3'd2,
    FINISH = 3'd3,
    TURN   = 3'd4
  } state_e;
`else
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DWELL  = 3'd1,
    STEP   = 3'd2,
    FINISH = 3'd3
  } state_e;
`endif

  // Counter load value for a dwell setting: a dwell of 0 behaves like 1.
  function automatic logic [DWELL_W-1:0] dwell_reload(input logic [DWELL_W-1:0] d);
    return (d == '0) ? '0 : d - DWELL_W'(1);
  endfunction

endpackage

// File: rtl/ico_step_calc.sv
// Combinational next-increment calculator with clamping at the sweep target.
// Ports:
//   increment  current increment value
//   step_inc   unsigned step magnitude
//   stop_inc   value the sweep must not pass
//   dir_up     1 = add step, 0 = subtract step
//   nxt_c      clamped next increment (combinational)
module ico_step_calc
  import ico_pkg::*;
(
  input  logic [INC_W-1:0] increment,
  input  logic [INC_W-1:0] step_inc,
  input  logic [INC_W-1:0] stop_inc,
  input  logic             dir_up,
  output logic [INC_W-1:0] nxt_c
);

  logic [INC_W:0] sum;
  logic [INC_W:0] diff;

  // One extra bit catches overflow going up and borrow going down.
  always_comb begin
    sum   = {1'b0, increment} + {1'b0, step_inc};
    diff  = {1'b0, increment} - {1'b0, step_inc};
    nxt_c = stop_inc;
    if (dir_up) begin
      if (sum <= {1'b0, stop_inc}) nxt_c = sum[INC_W-1:0];
    end else begin
      if (!diff[INC_W] && (diff[INC_W-1:0] >= stop_inc)) nxt_c = diff[INC_W-1:0];
    end
  end

endmodule

// File: rtl/ico_sweep_ctrl.sv
// Stepped frequency sweep sequencer for the ICO increment word.
// Steps the increment from start_inc to stop_inc by step_inc, holding each
// value for max(dwell,1)+1 cycles; the final value is held until the next
// start or an abort.
// Ports:
//   clk40MHz, rst_n        40 MHz clock, async active-low reset
//   start, abort           sweep start pulse / sweep terminate (priority)
//   start_inc, stop_inc    sweep end points, captured on start
//   step_inc, dwell        step magnitude and hold cycles, captured on start
//   increment              registered ICO increment drive
//   busy, step_stb, done   sweep active / value changed / normal completion
// Build option: SWEEP_TRIANGLE_EN sweeps back to start_inc after reaching
// stop_inc and pulses done only on return.
module ico_sweep_ctrl
  import ico_pkg::*;
(
  input  logic               clk40MHz,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [INC_W-1:0]   start_inc,
  input  logic [INC_W-1:0]   stop_inc,
  input  logic [INC_W-1:0]   step_inc,
  input  logic [DWELL_W-1:0] dwell,
  output logic [INC_W-1:0]   increment,
  output logic               busy,
  output logic               step_stb,
  output logic               done
);

  state_e             state_q, state_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] reload_q, reload_d;
  logic [INC_W-1:0]   tgt_q, tgt_d;
  logic [INC_W-1:0]   step_q, step_d;
  logic               dir_q, dir_d;
  logic [INC_W-1:0]   inc_d;
  logic               busy_d, stb_d, done_d;
  logic [INC_W-1:0]   nxt_c;
  logic               calc_dir;
  logic [INC_W-1:0]   calc_tgt;
`ifdef SWEEP_TRIANGLE_EN
  logic [INC_W-1:0]   start_q, start_d;
  logic               ret_q, ret_d;
`endif

  // The turnaround step already heads back toward start_inc.
`ifdef SWEEP_TRIANGLE_EN
  assign calc_dir = (state_q == TURN) ? ~dir_q : dir_q;
  assign calc_tgt = (state_q == TURN) ? start_q : tgt_q;
`else
  assign calc_dir = dir_q;
  assign calc_tgt = tgt_q;
`endif

  ico_step_calc u_step_calc (
    .increment (increment),
    .step_inc  (step_q),
    .stop_inc  (calc_tgt),
    .dir_up    (calc_dir),
    .nxt_c     (nxt_c)
  );

  // State and output registers.
  always_ff @(posedge clk40MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      reload_q  <= '0;
      tgt_q     <= '0;
      step_q    <= '0;
      dir_q     <= 1'b0;
      increment <= '0;
      busy      <= 1'b0;
      step_stb  <= 1'b0;
      done      <= 1'b0;
`ifdef SWEEP_TRIANGLE_EN
      start_q   <= '0;
      ret_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      reload_q  <= reload_d;
      tgt_q     <= tgt_d;
      step_q    <= step_d;
      dir_q     <= dir_d;
      increment <= inc_d;
      busy      <= busy_d;
      step_stb  <= stb_d;
      done      <= done_d;
`ifdef SWEEP_TRIANGLE_EN
      start_q   <= start_d;
      ret_q     <= ret_d;
`endif
    end
  end

  // Next-state and next-output logic; abort overrides everything.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    tgt_d    = tgt_q;
    step_d   = step_q;
    dir_d    = dir_q;
    inc_d    = increment;
    busy_d   = busy;
    stb_d    = 1'b0;
    done_d   = 1'b0;
`ifdef SWEEP_TRIANGLE_EN
    start_d  = start_q;
    ret_d    = ret_q;
`endif
    if (abort) begin
      state_d = IDLE;
      inc_d   = '0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            inc_d    = start_inc;
            busy_d   = 1'b1;
            stb_d    = 1'b1;
            cnt_d    = dwell_reload(dwell);
            reload_d = dwell_reload(dwell);
            tgt_d    = stop_inc;
            step_d   = step_inc;
            dir_d    = (stop_inc >= start_inc);
`ifdef SWEEP_TRIANGLE_EN
            start_d  = start_inc;
            ret_d    = 1'b0;
`endif
            state_d  = DWELL;
          end
        end
        DWELL: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - DWELL_W'(1);
          end else if ((increment == tgt_q) || (step_q == '0)) begin
`ifdef SWEEP_TRIANGLE_EN
            // Turn around only on the outbound leg of a non-degenerate sweep.
            if (!ret_q && (step_q != '0) && (increment != start_q)) state_d = TURN;
            else state_d = FINISH;
`else
            state_d = FINISH;
`endif
          end else begin
            state_d = STEP;
          end
        end
        STEP: begin
          inc_d   = nxt_c;
          stb_d   = 1'b1;
          cnt_d   = reload_q;
          state_d = DWELL;
        end
`ifdef SWEEP_TRIANGLE_EN
        TURN: begin
          inc_d   = nxt_c;
          stb_d   = 1'b1;
          cnt_d   = reload_q;
          dir_d   = ~dir_q;
          tgt_d   = start_q;
          ret_d   = 1'b1;
          state_d = DWELL;
        end
`endif
        FINISH: begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ico_sweep_ctrl.sv
// Self-checking bench for ico_sweep_ctrl: a reference model pushes the expected
// step/done events with their spacing into a queue when a sweep is launched,
// and the monitor loop pops and compares them as the DUT produces them.
module tb_ico_sweep_ctrl;
  import ico_pkg::*;

  logic               clk40MHz = 1'b0;
  logic               rst_n    = 1'b0;
  logic               start    = 1'b0;
  logic               abort    = 1'b0;
  logic [INC_W-1:0]   start_inc = '0;
  logic [INC_W-1:0]   stop_inc  = '0;
  logic [INC_W-1:0]   step_inc  = '0;
  logic [DWELL_W-1:0] dwell     = '0;
  logic [INC_W-1:0]   increment;
  logic               busy;
  logic               step_stb;
  logic               done;

  int n_total = 0;
  int n_bad   = 0;

  typedef struct {
    bit is_done;
    int val;
    int gap;
  } ev_t;
  ev_t exp_q[$];

  ico_sweep_ctrl dut (
    .clk40MHz  (clk40MHz),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .start_inc (start_inc),
    .stop_inc  (stop_inc),
    .step_inc  (step_inc),
    .dwell     (dwell),
    .increment (increment),
    .busy      (busy),
    .step_stb  (step_stb),
    .done      (done)
  );

  always #5 clk40MHz = ~clk40MHz;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk40MHz);
    #1;
  endtask

  task automatic push_ev(input bit is_done, input int val, input int gap);
    ev_t e;
    e.is_done = is_done;
    e.val     = val;
    e.gap     = gap;
    exp_q.push_back(e);
  endtask

  // Reference sweep: expected values and cycle spacing between events.
  task automatic push_model(input int s, input int p, input int st, input int dw,
                            output int final_val);
    int  d;
    int  v;
    int  nv;
    int  tgt;
    bit  up;
    bit  ret;
    d   = (dw == 0) ? 1 : dw;
    v   = s;
    tgt = p;
    up  = (p >= s);
    ret = 1'b0;
    push_ev(1'b0, v, 0);
    for (int k = 0; k < 1000; k++) begin
      if (v == tgt || st == 0) begin
`ifdef SWEEP_TRIANGLE_EN
        if (!ret && st != 0 && s != p) begin
          ret = 1'b1;
          up  = !up;
          tgt = s;
        end else break;
`else
        break;
`endif
      end
      if (up) begin
        nv = v + st;
        if (nv > tgt) nv = tgt;
      end else begin
        nv = v - st;
        if (nv < tgt) nv = tgt;
      end
      push_ev(1'b0, nv, d + 1);
      v = nv;
    end
    push_ev(1'b1, 0, d + 1);
    final_val = v;
  endtask

  // Pops and compares events as the DUT emits them; optional start poke while busy.
  task automatic drain(input int poke_at, input int budget);
    int  cyc;
    int  it;
    ev_t e;
    cyc = 0;
    it  = 0;
    while (exp_q.size() > 0 && it < budget) begin
      if (step_stb || done) begin
        e = exp_q.pop_front();
        check_eq("ev_kind", int'(done), int'(e.is_done));
        check_eq("ev_gap", cyc, e.gap);
        if (!e.is_done) begin
          check_eq("inc", int'(increment), e.val);
          check_eq("busy_on", int'(busy), 1);
        end else begin
          check_eq("busy_off", int'(busy), 0);
        end
        cyc = 0;
      end
      if (it == poke_at) begin
        start     = 1'b1;
        start_inc = INC_W'(7);
        stop_inc  = INC_W'(9000);
        step_inc  = INC_W'(1);
      end
      tick();
      start = 1'b0;
      cyc++;
      it++;
    end
    if (exp_q.size() > 0) begin
      check_eq("timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic check_hold(input int final_val, input int n);
    for (int i = 0; i < n; i++) begin
      check_eq("hold_inc", int'(increment), final_val);
      check_eq("hold_busy", int'(busy), 0);
      check_eq("hold_stb", int'(step_stb), 0);
      check_eq("hold_done", int'(done), 0);
      tick();
    end
  endtask

  task automatic launch(input int s, input int p, input int st, input int dw);
    @(negedge clk40MHz);
    start_inc = INC_W'(s);
    stop_inc  = INC_W'(p);
    step_inc  = INC_W'(st);
    dwell     = DWELL_W'(dw);
    start     = 1'b1;
    tick();
    start     = 1'b0;
    // Captured config must be unaffected by later input changes.
    start_inc = INC_W'($urandom);
    stop_inc  = INC_W'($urandom);
    step_inc  = INC_W'($urandom);
    dwell     = DWELL_W'($urandom_range(0, 9));
  endtask

  task automatic run_sweep(input int s, input int p, input int st, input int dw,
                           input int poke_at);
    int fv;
    push_model(s, p, st, dw, fv);
    launch(s, p, st, dw);
    drain(poke_at, 2000);
    check_hold(fv, 3);
  endtask

  initial begin
    repeat (2) @(negedge clk40MHz);
    check_eq("rst_inc", int'(increment), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_stb", int'(step_stb), 0);
    check_eq("rst_done", int'(done), 0);
    rst_n = 1'b1;

    run_sweep(100, 130, 10, 3, -1);
    run_sweep(50, 5, 20, 1, -1);
    run_sweep(3, 0, 10, 2, -1);
    run_sweep(32760, 32767, 100, 1, -1);
    run_sweep(100, 130, 10, 0, -1);
    run_sweep(200, 500, 0, 2, -1);
    run_sweep(100, 130, 10, 3, 6);
`ifdef SWEEP_TRIANGLE_EN
    run_sweep(0, 20, 10, 1, -1);
`endif

    // Abort while idle with a nonzero held increment clears it.
    @(negedge clk40MHz);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("abort_idle_inc", int'(increment), 0);
    check_eq("abort_idle_busy", int'(busy), 0);

    // Abort mid-dwell on the second value, with a simultaneous start.
    push_ev(1'b0, 100, 0);
    push_ev(1'b0, 110, 4);
    launch(100, 130, 10, 3);
    drain(-1, 100);
    @(negedge clk40MHz);
    abort = 1'b1;
    start = 1'b1;
    start_inc = INC_W'(500);
    stop_inc  = INC_W'(600);
    tick();
    abort = 1'b0;
    start = 1'b0;
    check_eq("abort_inc", int'(increment), 0);
    check_eq("abort_busy", int'(busy), 0);
    check_eq("abort_stb", int'(step_stb), 0);
    check_hold(0, 8);

    // Asynchronous reset mid-sweep.
    launch(100, 130, 10, 3);
    repeat (5) tick();
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("arst_inc", int'(increment), 0);
    check_eq("arst_busy", int'(busy), 0);
    check_eq("arst_stb", int'(step_stb), 0);
    check_eq("arst_done", int'(done), 0);
    @(negedge clk40MHz);
    rst_n = 1'b1;
    tick();
    check_hold(0, 3);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
